// File: rtl/fx2_adc_streamer.sv
// -----------------------------------------------------------------------------
// fx2_adc_streamer
//
// Captures a parallel ADC bus every clock, decimates it by a programmable
// divider, buffers the decimated samples in a small FIFO and writes them to
// a Cypress FX2 slave FIFO (synchronous write mode, IFCLK domain).
//
// Optional feature macro: FX2_ADC_PKTEND_EN
//   defined   -> after a flush drains the FIFO, a 1-cycle PKTENDN strobe
//                commits the short packet, but only if at least one word
//                was written since the last strobe or reset.
//   undefined -> no PKTEND state; PKTENDN is tied high.
//
// Parameters
//   ADC_W      ADC sample width (1..FD_W)
//   FD_W       FX2 FD bus width (8 or 16)
//   FIFO_DEPTH buffer depth in words (power of two, 4..256)
//   DIV_W      width of the decimation divider input
//
// Ports
//   CLK       in   48 MHz IFCLK, rising edge
//   RST       in   asynchronous active-high reset
//   EN        in   streaming enable
//   DIV       in   sample period in CLK cycles (0 and 1 mean every cycle)
//   ADC_DATA  in   ADC sample bus
//   FULLN     in   FX2 endpoint full flag, active-low
//   FD        out  FX2 data bus (registered, holds when idle)
//   SLWRN     out  FX2 write strobe, active-low (registered)
//   PKTENDN   out  FX2 packet-end strobe, active-low (registered)
//   LEVEL     out  FIFO occupancy
//   OVF_CNT   out  saturating count of samples dropped on a full FIFO
// -----------------------------------------------------------------------------
module fx2_adc_streamer #(
    parameter int ADC_W      = 8,
    parameter int FD_W       = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 26
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          EN,
    input  logic [DIV_W-1:0]              DIV,
    input  logic [ADC_W-1:0]              ADC_DATA,
    input  logic                          FULLN,
    output logic [FD_W-1:0]               FD,
    output logic                          SLWRN,
    output logic                          PKTENDN,
    output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
    output logic [15:0]                   OVF_CNT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

`ifdef FX2_ADC_PKTEND_EN
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_PKTEND} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;
`endif

    state_t state, state_next;

    logic [ADC_W-1:0] sample_p1;
    logic [FD_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level;
    logic [15:0]      ovf;
    logic [DIV_W-1:0] cnt, div_lat;

    logic run, last, tick, full, push_ok, drop, pop;
    logic [FD_W-1:0] push_word;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---- stage p1: raw ADC capture, every cycle ----
    always_ff @(posedge CLK) begin
        sample_p1 <= ADC_DATA;
    end

    // MSB-align the sample on the FD bus, zero-filling the LSBs.
    assign push_word = FD_W'(sample_p1) << (FD_W - ADC_W);

    // The divider only runs while streaming with EN high, so an EN pulse
    // seen during FLUSH/PKTEND cannot produce ticks.
    assign run  = (state == S_STREAM) && EN;
    // div_lat holds the period in force; DIV is re-sampled only at a wrap
    // (or while the counter is parked), so mid-period DIV changes wait.
    assign last = (div_lat <= DIV_W'(1)) || (cnt >= div_lat - DIV_W'(1));
    assign tick = run && (cnt == '0);

    assign full    = (level == LW'(FIFO_DEPTH));
    assign push_ok = tick && !full;
    assign drop    = tick && full;
    // Pop decision uses the pre-push level: no same-cycle bypass.
    assign pop     = ((state == S_STREAM) || (state == S_FLUSH)) &&
                     (level != '0) && FULLN;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt     <= '0;
            div_lat <= '0;
        end else if (!run || last) begin
            cnt     <= '0;
            div_lat <= DIV;
        end else begin
            cnt     <= cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (EN)  state_next = S_STREAM;
            S_STREAM: if (!EN) state_next = S_FLUSH;
`ifdef FX2_ADC_PKTEND_EN
            S_FLUSH:  if (level == '0) state_next = S_PKTEND;
            S_PKTEND: state_next = S_IDLE;
`else
            S_FLUSH:  if (level == '0) state_next = S_IDLE;
`endif
            default:  state_next = S_IDLE;
        endcase
    end

    // ---- stage p2: FIFO bookkeeping and FX2 write port ----
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= '0;
            FD     <= '0;
            SLWRN  <= 1'b1;
        end else begin
            state <= state_next;
            SLWRN <= ~pop;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                FD     <= mem[rd_ptr];
            end
            if (drop) ovf <= sat_inc(ovf);
            unique case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef FX2_ADC_PKTEND_EN
    logic written, pkt_fire;

    // Strobe is registered on entry to PKTEND so it coincides with that state.
    assign pkt_fire = (state_next == S_PKTEND) && written;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            written <= 1'b0;
            PKTENDN <= 1'b1;
        end else begin
            PKTENDN <= ~pkt_fire;
            if (pkt_fire)  written <= 1'b0;
            else if (pop)  written <= 1'b1;
        end
    end
`else
    assign PKTENDN = 1'b1;
`endif

    assign LEVEL   = level;
    assign OVF_CNT = ovf;

endmodule

// File: tb/tb_fx2_adc_streamer.sv
module tb_fx2_adc_streamer;

    localparam int ADC_W = 10;
    localparam int FD_W  = 16;
    localparam int DEPTH = 16;
    localparam int DIV_W = 26;
`ifdef FX2_ADC_PKTEND_EN
    localparam bit PKT = 1'b1;
`else
    localparam bit PKT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             fulln;
    logic [DIV_W-1:0] div;
    logic [ADC_W-1:0] adc;
    logic [FD_W-1:0]  fd;
    logic             slwrn;
    logic             pktendn;
    logic [4:0]       level;
    logic [15:0]      ovf_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fx2_adc_streamer #(
        .ADC_W(ADC_W), .FD_W(FD_W), .FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)
    ) dut (
        .CLK(clk), .RST(rst), .EN(en), .DIV(div), .ADC_DATA(adc),
        .FULLN(fulln), .FD(fd), .SLWRN(slwrn), .PKTENDN(pktendn),
        .LEVEL(level), .OVF_CNT(ovf_cnt)
    );

    // ---------------- reference model (queue based) ----------------
    // mode: 0 idle, 1 streaming, 2 flushing, 3 packet-end
    int               m_mode;
    logic [FD_W-1:0]  m_q[$];
    int               m_cnt;
    int               m_per;
    logic [ADC_W-1:0] m_smp;
    logic [FD_W-1:0]  m_fd;
    logic             m_slwrn;
    logic             m_pktendn;
    int               m_ovf;
    bit               m_wrote;

    function automatic logic [FD_W-1:0] word_of(input logic [ADC_W-1:0] s);
        return {s, {(FD_W-ADC_W){1'b0}}};
    endfunction

    function automatic logic [ADC_W-1:0] vs(input int k);
        return ADC_W'(10'h155 + k * 7);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_q.delete(); m_cnt = 0; m_per = 0; m_fd = '0;
        m_slwrn = 1'b1; m_pktendn = 1'b1; m_ovf = 0; m_wrote = 0;
    endtask

    task automatic model_step();
        int sz;
        int period;
        bit tk, pp;
        sz = m_q.size();
        tk = (m_mode == 1) && en && (m_cnt == 0);
        pp = ((m_mode == 1) || (m_mode == 2)) && (sz > 0) && fulln;
        m_slwrn = !pp;
        m_pktendn = 1'b1;
        if (pp) begin
            m_fd = m_q.pop_front();
            m_wrote = 1;
        end
        if (tk) begin
            if (sz == DEPTH) begin
                if (m_ovf < 65535) m_ovf++;
            end else begin
                m_q.push_back(word_of(m_smp));
            end
        end
        if ((m_mode == 1) && en) begin
            period = (m_per < 1) ? 1 : m_per;
            if (m_cnt + 1 >= period) begin
                m_cnt = 0; m_per = int'(div);
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0; m_per = int'(div);
        end
        case (m_mode)
            0: if (en) m_mode = 1;
            1: if (!en) m_mode = 2;
            2: if (sz == 0) begin
                   if (PKT) begin
                       if (m_wrote) begin m_pktendn = 1'b0; m_wrote = 0; end
                       m_mode = 3;
                   end else begin
                       m_mode = 0;
                   end
               end
            default: m_mode = 0;
        endcase
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("slwrn", 32'(slwrn), 32'(m_slwrn));
        chk("pktendn", 32'(pktendn), 32'(m_pktendn));
        chk("level", 32'(level), 32'(m_q.size()));
        chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
        chk("fd", 32'(fd), 32'(m_fd));
    endtask

    // One clock: inputs are already stable; model follows the edge,
    // outputs are checked on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        m_smp = adc;
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; fulln = 1'b1;
        model_reset();
        step(); step();
        rst = 1'b0;
        step();
    endtask

    typedef struct {
        logic             en;
        logic             fulln;
        logic [ADC_W-1:0] adc;
        logic             exp_slwrn;
        logic             exp_pktendn;
        int               exp_level;
        logic [FD_W-1:0]  exp_fd;
    } vec_t;

    vec_t tbl[7];

    initial begin
        rst = 1'b1; en = 1'b0; fulln = 1'b1; div = '0; adc = '0;
        model_reset();

        // ---- directed vector table: DIV=2, short stream then flush ----
        tbl[0] = '{1'b1, 1'b1, 10'h200, 1'b1, 1'b1, 0, 16'h0000};
        tbl[1] = '{1'b1, 1'b1, 10'h201, 1'b1, 1'b1, 1, 16'h0000};
        tbl[2] = '{1'b1, 1'b1, 10'h202, 1'b0, 1'b1, 0, 16'h8000};
        tbl[3] = '{1'b1, 1'b1, 10'h203, 1'b1, 1'b1, 1, 16'h8000};
        tbl[4] = '{1'b0, 1'b1, 10'h204, 1'b0, 1'b1, 0, 16'h8080};
        tbl[5] = '{1'b0, 1'b1, 10'h205, 1'b1, !PKT,  0, 16'h8080};
        tbl[6] = '{1'b0, 1'b1, 10'h206, 1'b1, 1'b1, 0, 16'h8080};

        div = 26'd2;
        do_reset();
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_ovf", 32'(ovf_cnt), 32'd0);
        chk("reset_slwrn", 32'(slwrn), 32'd1);
        chk("reset_pktendn", 32'(pktendn), 32'd1);
        chk("reset_fd", 32'(fd), 32'd0);

        for (int i = 0; i < 7; i++) begin
            en = tbl[i].en; fulln = tbl[i].fulln; adc = tbl[i].adc;
            step();
            chk($sformatf("tbl%0d_slwrn", i), 32'(slwrn), 32'(tbl[i].exp_slwrn));
            chk($sformatf("tbl%0d_pktendn", i), 32'(pktendn), 32'(tbl[i].exp_pktendn));
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].exp_level));
            chk($sformatf("tbl%0d_fd", i), 32'(fd), 32'(tbl[i].exp_fd));
        end

        // ---- DIV=4 ramp: one write per 4 cycles, samples 0,4,8 ----
        div = 26'd4;
        do_reset();
        en = 1'b1; fulln = 1'b1; adc = vs(0);
        step();
        for (int k = 1; k <= 12; k++) begin
            adc = vs(k);
            step();
            chk("div4_slwrn", 32'(slwrn), (k % 4 == 2) ? 32'd0 : 32'd1);
            if (k % 4 == 2) chk("div4_fd", 32'(fd), 32'(word_of(vs(k - 2))));
            chk("div4_ovf", 32'(ovf_cnt), 32'd0);
        end

        // ---- backpressure, push+pop at full, in-order drain ----
        div = 26'd1;
        do_reset();
        en = 1'b1; fulln = 1'b0; adc = vs(0);
        step();
        for (int k = 1; k <= 40; k++) begin
            adc = vs(k);
            step();
        end
        chk("bp_level", 32'(level), 32'd16);
        chk("bp_ovf", 32'(ovf_cnt), 32'd24);
        fulln = 1'b1; adc = vs(41);
        step();
        chk("pp_level", 32'(level), 32'd15);
        chk("pp_ovf", 32'(ovf_cnt), 32'd25);
        chk("pp_slwrn", 32'(slwrn), 32'd0);
        chk("pp_fd", 32'(fd), 32'(word_of(vs(0))));
        en = 1'b0;
        for (int j = 1; j < 16; j++) begin
            step();
            chk("drain_slwrn", 32'(slwrn), 32'd0);
            chk("drain_fd", 32'(fd), 32'(word_of(vs(j))));
        end
        chk("drain_level", 32'(level), 32'd0);
        step();
        chk("drain_pktendn", 32'(pktendn), PKT ? 32'd0 : 32'd1);
        chk("drain_idle_slwrn", 32'(slwrn), 32'd1);
        step();
        chk("drain_pktendn_once", 32'(pktendn), 32'd1);

        // ---- mid-transfer reset at LEVEL=7 ----
        do_reset();
        en = 1'b1; fulln = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            adc = vs(100 + k);
            step();
        end
        en = 1'b0; fulln = 1'b1;
        for (int j = 0; j < 9; j++) step();
        chk("mid_level_before", 32'(level), 32'd7);
        chk("mid_ovf_before", 32'(ovf_cnt), 32'd4);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("mid_level", 32'(level), 32'd0);
        chk("mid_ovf", 32'(ovf_cnt), 32'd0);
        chk("mid_slwrn", 32'(slwrn), 32'd1);
        chk("mid_fd", 32'(fd), 32'd0);
        step();
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            chk("post_rst_slwrn", 32'(slwrn), 32'd1);
            chk("post_rst_pktendn", 32'(pktendn), 32'd1);
        end

        // ---- overflow counter saturation ----
        div = 26'd0;
        do_reset();
        en = 1'b1; fulln = 1'b0;
        step();
        for (int k = 0; k < 16 + 65535; k++) begin
            adc = ADC_W'($urandom);
            step();
        end
        chk("sat_reach", 32'(ovf_cnt), 32'hFFFF);
        for (int k = 0; k < 5; k++) step();
        chk("sat_hold", 32'(ovf_cnt), 32'hFFFF);

        // ---- randomized traffic against the model ----
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) == 0) en = ~en;
            fulln = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) div = DIV_W'($urandom_range(0, 5));
            adc = ADC_W'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            step();
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
